// File: rtl/csa_resolve_stage_pkg.sv
// Shared MAC datapath definitions: CSA width, tag type and leading-zero-count width.
// Imported by the CSA feeder, this resolve stage and the normaliser.
package MacPkg;

  localparam int MAC_XLEN = 49;
  localparam int MAC_TAGW = 8;

  function automatic int lzw_of(input int xlen);
    return $clog2(xlen + 1);
  endfunction

  localparam int MAC_LZW = lzw_of(MAC_XLEN);

  typedef logic [MAC_TAGW-1:0] mac_tag_t;

endpackage

// File: rtl/csa_resolve_stage_lzc.sv
// LeadingZeroCounter: combinational leading-zero count, built as a binary tree of halves.
// The output equals W when the input is all zeros.
module LeadingZeroCounter #(
  parameter int W  = 49,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  if (W == 1) begin : g_leaf
    assign cnt = ~d;
  end else begin : g_node
    localparam int WH = W - W / 2;
    localparam int WL = W / 2;
    localparam int CH = $clog2(WH + 1);
    localparam int CL = $clog2(WL + 1);

    logic [CH-1:0] cnt_hi;
    logic [CL-1:0] cnt_lo;

    LeadingZeroCounter #(.W(WH)) u_hi (
      .d   (d[W-1:WL]),
      .cnt (cnt_hi)
    );

    LeadingZeroCounter #(.W(WL)) u_lo (
      .d   (d[WL-1:0]),
      .cnt (cnt_lo)
    );

    // Upper half all zero (count saturated at its width): continue into the lower half.
    assign cnt = (cnt_hi == CH'(WH)) ? (CW'(WH) + CW'(cnt_lo)) : CW'(cnt_hi);
  end

endmodule

// File: rtl/csa_resolve_stage.sv
// csa_resolve_stage: 2-stage valid/ready pipeline collapsing CSA sum/carry into sign, |x| and LZC.
// CSA_RESOLVE_LZC_EN builds the LZC; when undefined lzc_o is tied to 0.
module csa_resolve_stage
  import MacPkg::*;
#(
  parameter int XLEN = MAC_XLEN,
  parameter int TAGW = MAC_TAGW,
  parameter int LZW  = lzw_of(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] Sum_i,
  input  logic [XLEN-1:0] Cy_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            neg_o,
  output logic [XLEN-1:0] mag_o,
  output logic [LZW-1:0]  lzc_o,
  output logic [TAGW-1:0] tag_o
);

  function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + XLEN'(1)) : v;
  endfunction

  logic                   vld_p1;
  logic                   vld_p2;
  logic signed [XLEN-1:0] sum_p1;
  logic        [TAGW-1:0] tag_p1;
  logic signed [XLEN-1:0] res_p2;
  logic                   neg_p2;
  logic        [XLEN-1:0] mag_p2;
  logic        [TAGW-1:0] tag_p2;

  logic                   s1_adv;
  logic                   s2_adv;
  logic        [XLEN-1:0] sum_nxt;
  logic        [XLEN-1:0] mag_nxt;

  assign s2_adv     = !vld_p2 || out_ready_i;
  assign s1_adv     = !vld_p1 || s2_adv;
  assign in_ready_o = s1_adv;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= in_valid_i;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  // ---- Stage 1: carry-propagate add; Cy[XLEN-1] and the carry-out fall off the top ----
  assign sum_nxt = Sum_i + {Cy_i[XLEN-2:0], 1'b0};

  always_ff @(posedge clk_i) begin
    if (s1_adv && in_valid_i) begin
      sum_p1 <= sum_nxt;
      tag_p1 <= tag_i;
    end
  end

  // ---- Stage 2: sign, magnitude and leading-zero count ----
  assign mag_nxt = abs_mag(sum_p1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_p2 <= '0;
      neg_p2 <= 1'b0;
      mag_p2 <= '0;
      tag_p2 <= '0;
    end else if (s2_adv && vld_p1) begin
      res_p2 <= sum_p1;
      neg_p2 <= sum_p1[XLEN-1];
      mag_p2 <= mag_nxt;
      tag_p2 <= tag_p1;
    end
  end

`ifdef CSA_RESOLVE_LZC_EN
  logic [LZW-1:0] lzc_nxt;
  logic [LZW-1:0] lzc_p2;

  LeadingZeroCounter #(.W(XLEN)) u_lzc (
    .d   (mag_nxt),
    .cnt (lzc_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lzc_p2 <= '0;
    end else if (s2_adv && vld_p1) begin
      lzc_p2 <= lzc_nxt;
    end
  end

  assign lzc_o = lzc_p2;
`else
  assign lzc_o = '0;
`endif

  assign out_valid_o = vld_p2;
  assign res_o       = res_p2;
  assign neg_o       = neg_p2;
  assign mag_o       = mag_p2;
  assign tag_o       = tag_p2;

endmodule

// File: tb/tb_csa_resolve_stage.sv
// Directed self-checking bench for csa_resolve_stage: arithmetic corners, backpressure, async reset.
// LZC expectations follow CSA_RESOLVE_LZC_EN (0 when the macro is undefined).
module tb_csa_resolve_stage;

  localparam int XLEN = 49;
  localparam int TAGW = 8;
  localparam int LZW  = 6;
`ifdef CSA_RESOLVE_LZC_EN
  localparam bit LZC_ON = 1'b1;
`else
  localparam bit LZC_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] cy;
  logic [TAGW-1:0] tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            neg;
  logic [XLEN-1:0] mag;
  logic [LZW-1:0]  lzc;
  logic [TAGW-1:0] rtag;

  int checks = 0;
  int errors = 0;

  csa_resolve_stage #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .Sum_i       (sum),
    .Cy_i        (cy),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .res_o       (res),
    .neg_o       (neg),
    .mag_o       (mag),
    .lzc_o       (lzc),
    .tag_o       (rtag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LZW-1:0] exp_lzc(input int v);
    return LZC_ON ? LZW'(v) : '0;
  endfunction

  // Drives one pair into an empty pipeline and captures what appears one and two cycles later.
  task automatic run_single(input logic [XLEN-1:0] s, input logic [XLEN-1:0] c,
                            input logic [TAGW-1:0] t,
                            output logic ve, output logic vl, output logic [XLEN-1:0] r,
                            output logic n, output logic [XLEN-1:0] m,
                            output logic [LZW-1:0] l, output logic [TAGW-1:0] tg);
    @(negedge clk);
    sum = s; cy = c; tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ve = out_valid;
    @(negedge clk);
    vl = out_valid; r = res; n = neg; m = mag; l = lzc; tg = rtag;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; sum = '0; cy = '0; tag = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (res !== '0) begin errors++; $display("FAIL reset_res got %0h want 0", res); end
    checks++; if (mag !== '0 || neg !== 1'b0) begin errors++; $display("FAIL reset_mag_neg got %0h/%0b want 0/0", mag, neg); end
    checks++; if (lzc !== '0 || rtag !== '0) begin errors++; $display("FAIL reset_lzc_tag got %0d/%0h want 0/0", lzc, rtag); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_basic();
    logic ve, vl, n; logic [XLEN-1:0] r, m; logic [LZW-1:0] l; logic [TAGW-1:0] tg;
    run_single(49'd5, 49'd3, 8'h11, ve, vl, r, n, m, l, tg);
    checks++; if (ve !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", ve); end
    checks++; if (vl !== 1'b1) begin errors++; $display("FAIL basic_latency_valid got %0b want 1", vl); end
    checks++; if (r !== 49'd11) begin errors++; $display("FAIL basic_res got %0d want 11", r); end
    checks++; if (n !== 1'b0) begin errors++; $display("FAIL basic_neg got %0b want 0", n); end
    checks++; if (m !== 49'd11) begin errors++; $display("FAIL basic_mag got %0d want 11", m); end
    checks++; if (l !== exp_lzc(45)) begin errors++; $display("FAIL basic_lzc got %0d want %0d", l, exp_lzc(45)); end
    checks++; if (tg !== 8'h11) begin errors++; $display("FAIL basic_tag got %0h want 11", tg); end
  endtask

  task automatic test_negative();
    logic ve, vl, n; logic [XLEN-1:0] r, m; logic [LZW-1:0] l; logic [TAGW-1:0] tg;
    run_single(49'h1FFFFFFFFFFFF, 49'd0, 8'h22, ve, vl, r, n, m, l, tg);
    checks++; if (r !== 49'h1FFFFFFFFFFFF) begin errors++; $display("FAIL neg_res got %0h want 1ffffffffffff", r); end
    checks++; if (n !== 1'b1) begin errors++; $display("FAIL neg_neg got %0b want 1", n); end
    checks++; if (m !== 49'd1) begin errors++; $display("FAIL neg_mag got %0h want 1", m); end
    checks++; if (l !== exp_lzc(48)) begin errors++; $display("FAIL neg_lzc got %0d want %0d", l, exp_lzc(48)); end
    checks++; if (tg !== 8'h22) begin errors++; $display("FAIL neg_tag got %0h want 22", tg); end
  endtask

  task automatic test_extremes();
    logic ve, vl, n; logic [XLEN-1:0] r, m; logic [LZW-1:0] l; logic [TAGW-1:0] tg;
    run_single(49'h1000000000000, 49'd0, 8'h33, ve, vl, r, n, m, l, tg);
    checks++; if (n !== 1'b1) begin errors++; $display("FAIL minneg_neg got %0b want 1", n); end
    checks++; if (m !== 49'h1000000000000) begin errors++; $display("FAIL minneg_mag got %0h want 1000000000000", m); end
    checks++; if (l !== exp_lzc(0)) begin errors++; $display("FAIL minneg_lzc got %0d want %0d", l, exp_lzc(0)); end
    run_single(49'd0, 49'd0, 8'h44, ve, vl, r, n, m, l, tg);
    checks++; if (r !== '0 || n !== 1'b0) begin errors++; $display("FAIL zero_res_neg got %0h/%0b want 0/0", r, n); end
    checks++; if (m !== '0) begin errors++; $display("FAIL zero_mag got %0h want 0", m); end
    checks++; if (l !== exp_lzc(49)) begin errors++; $display("FAIL zero_lzc got %0d want %0d", l, exp_lzc(49)); end
    checks++; if (tg !== 8'h44) begin errors++; $display("FAIL zero_tag got %0h want 44", tg); end
  endtask

  task automatic test_carry_wrap();
    logic ve, vl, n; logic [XLEN-1:0] r, m; logic [LZW-1:0] l; logic [TAGW-1:0] tg;
    run_single(49'h1FFFFFFFFFFFE, 49'h1000000000001, 8'h55, ve, vl, r, n, m, l, tg);
    checks++; if (vl !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b want 1", vl); end
    checks++; if (r !== '0) begin errors++; $display("FAIL wrap_res got %0h want 0", r); end
    checks++; if (n !== 1'b0 || m !== '0) begin errors++; $display("FAIL wrap_neg_mag got %0b/%0h want 0/0", n, m); end
    checks++; if (l !== exp_lzc(49)) begin errors++; $display("FAIL wrap_lzc got %0d want %0d", l, exp_lzc(49)); end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] exp_res [4];
    logic [TAGW-1:0] exp_tag [4];
    logic [XLEN-1:0] snap_res, snap_mag;
    logic [TAGW-1:0] snap_tag;
    logic            stalled;
    int              acc, got;
    for (int i = 0; i < 4; i++) begin
      exp_res[i] = XLEN'(100 * i + 7 + 2 * (i + 1));
      exp_tag[i] = TAGW'(8'hA0 + i);
    end
    acc = 0; got = 0; stalled = 1'b0;
    snap_res = '0; snap_mag = '0; snap_tag = '0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (res !== snap_res || mag !== snap_mag || rtag !== snap_tag) begin
          errors++; $display("FAIL bp_stable got %0d/%0h want %0d/%0h", res, rtag, snap_res, snap_tag);
        end
      end
      out_ready = (c >= 4);
      if (acc < 4) begin
        in_valid = 1'b1;
        sum = XLEN'(100 * acc + 7);
        cy  = XLEN'(acc + 1);
        tag = TAGW'(8'hA0 + acc);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready && acc == 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %0b want 0", in_ready); end
      end
      if (c == 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_shift got %0b want 1", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (res !== exp_res[got] || rtag !== exp_tag[got]) begin
          errors++; $display("FAIL bp_order[%0d] got %0d/%0h want %0d/%0h", got, res, rtag, exp_res[got], exp_tag[got]);
        end
        got++;
      end
      stalled  = out_valid && !out_ready;
      snap_res = res; snap_mag = mag; snap_tag = rtag;
      if (in_valid && in_ready) acc++;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic ve, vl, n; logic [XLEN-1:0] r, m; logic [LZW-1:0] l; logic [TAGW-1:0] tg;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; sum = 49'd1000; cy = 49'd1; tag = 8'hC1;
    @(negedge clk);
    sum = 49'd2000; cy = 49'd2; tag = 8'hC2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_full got %0b/%0b want 1/0", out_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %0b want 0", out_valid); end
    checks++; if (res !== '0 || rtag !== '0) begin errors++; $display("FAIL rst_mid_data got %0h/%0h want 0/0", res, rtag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    run_single(49'd40, 49'd1, 8'h77, ve, vl, r, n, m, l, tg);
    checks++; if (ve !== 1'b0 || vl !== 1'b1) begin errors++; $display("FAIL rst_mid_latency got %0b%0b want 01", ve, vl); end
    checks++; if (r !== 49'd42 || tg !== 8'h77) begin errors++; $display("FAIL rst_mid_result got %0d/%0h want 42/77", r, tg); end
    checks++; if (l !== exp_lzc(43)) begin errors++; $display("FAIL rst_mid_lzc got %0d want %0d", l, exp_lzc(43)); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_extremes();
    test_carry_wrap();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
